// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel-rate divider, x/y counters, VGA syncs,
// video-active qualifier, and line/frame strobes for the pong display path.
module vga_scan_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] Y_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        ST_RESET,
        ST_RUN
    } state_t;

    state_t     state;
    logic [3:0] div;

    logic [3:0] div_next;
    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       wrap_x;

    // The first edge out of reset only arms the counters, so the divider
    // sits at 0 for one full clk and a CLK_DIV=1 build ticks immediately.
    always_comb begin
        div_next = '0;
        x_next   = '0;
        y_next   = '0;
        wrap_x   = 1'b0;
        if (state == ST_RUN) begin
            wrap_x   = p_tick && (x == X_LAST);
            div_next = p_tick ? '0 : div + 4'd1;
            x_next   = x;
            y_next   = y;
            if (p_tick) begin
                x_next = (x == X_LAST) ? '0 : x + 10'd1;
            end
            if (wrap_x) begin
                y_next = (y == Y_LAST) ? '0 : y + 10'd1;
            end
        end
    end

    // Syncs and video_on are computed from next x/y so they move with x/y.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RESET;
            div        <= '0;
            p_tick     <= 1'b0;
            x          <= '0;
            y          <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            video_on   <= 1'b0;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state      <= ST_RUN;
            div        <= div_next;
            p_tick     <= (div_next == DIV_LAST);
            x          <= x_next;
            y          <= y_next;
            hsync      <= !((x_next >= HS_START) && (x_next < HS_END));
            vsync      <= !((y_next >= VS_START) && (y_next < VS_END));
            video_on   <= (x_next < X_VIS) && (y_next < Y_VIS);
            line_tick  <= wrap_x;
            frame_tick <= wrap_x && (y_next == Y_VIS);
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench: a time-based raster model predicts every clk's outputs for
// a CLK_DIV=4 and a CLK_DIV=1 instance on a shrunken geometry, with random resets.
module tb_vga_scan_gen;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 4;
    localparam int VA = 10, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic       line_tick;
        logic       frame_tick;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       p_tick_a, hsync_a, vsync_a, video_on_a, line_tick_a, frame_tick_a;
    logic [9:0] x_a, y_a;
    logic       p_tick_b, hsync_b, vsync_b, video_on_b, line_tick_b, frame_tick_b;
    logic [9:0] x_b, y_b;

    vga_scan_gen #(
        .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut_a (
        .clk(clk), .reset(reset), .p_tick(p_tick_a), .x(x_a), .y(y_a),
        .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
        .line_tick(line_tick_a), .frame_tick(frame_tick_a)
    );

    vga_scan_gen #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut_b (
        .clk(clk), .reset(reset), .p_tick(p_tick_b), .x(x_b), .y(y_b),
        .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
        .line_tick(line_tick_b), .frame_tick(frame_tick_b)
    );

    int errors = 0;
    int checks = 0;
    int t = -1;
    obs_t q_a[$];
    obs_t q_b[$];

    // t counts clks since the first edge that saw reset low; t<0 means in reset.
    function automatic obs_t model(input int tt, input int cdiv);
        obs_t o;
        int pix, px, py, ph;
        if (tt < 0) begin
            o = '0;
            o.hsync = 1'b1;
            o.vsync = 1'b1;
            return o;
        end
        ph  = tt % cdiv;
        pix = tt / cdiv;
        px  = pix % HT;
        py  = (pix / HT) % VT;
        o.p_tick     = (ph == cdiv - 1);
        o.x          = 10'(px);
        o.y          = 10'(py);
        o.hsync      = !(px >= HA + HFP && px < HA + HFP + HS);
        o.vsync      = !(py >= VA + VFP && py < VA + VFP + VS);
        o.video_on   = (px < HA) && (py < VA);
        o.line_tick  = (ph == 0) && (px == 0) && (pix > 0);
        o.frame_tick = (ph == 0) && (px == 0) && (py == VA);
        return o;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare(input string tag, input obs_t a, input obs_t e);
        check({tag, ".p_tick"},     int'(a.p_tick),     int'(e.p_tick));
        check({tag, ".x"},          int'(a.x),          int'(e.x));
        check({tag, ".y"},          int'(a.y),          int'(e.y));
        check({tag, ".hsync"},      int'(a.hsync),      int'(e.hsync));
        check({tag, ".vsync"},      int'(a.vsync),      int'(e.vsync));
        check({tag, ".video_on"},   int'(a.video_on),   int'(e.video_on));
        check({tag, ".line_tick"},  int'(a.line_tick),  int'(e.line_tick));
        check({tag, ".frame_tick"}, int'(a.frame_tick), int'(e.frame_tick));
    endtask

    always @(posedge clk) begin
        if (reset) t = -1;
        else       t = t + 1;
        q_a.push_back(model(t, 4));
        q_b.push_back(model(t, 1));
    end

    always @(negedge clk) begin
        obs_t act, exp;
        if (q_a.size() > 0) begin
            exp = q_a.pop_front();
            act = {p_tick_a, x_a, y_a, hsync_a, vsync_a, video_on_a, line_tick_a, frame_tick_a};
            compare("div4", act, exp);
        end
        if (q_b.size() > 0) begin
            exp = q_b.pop_front();
            act = {p_tick_b, x_b, y_b, hsync_b, vsync_b, video_on_b, line_tick_b, frame_tick_b};
            compare("div1", act, exp);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (1800) @(negedge clk);
        repeat ($urandom_range(50, 1500)) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2000) @(negedge clk);
        repeat ($urandom_range(1, 1700)) @(negedge clk);
        reset = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b0;
        repeat (3600) @(negedge clk);
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
